// File: rtl/alu_pkg.sv
// ALU-side package: opcode encoding and the command sequencer state encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        op_add = 4'd0,
        op_adc = 4'd1,
        op_sub = 4'd2,
        op_sbb = 4'd3,
        op_and = 4'd4,
        op_or  = 4'd5,
        op_xor = 4'd6,
        op_not = 4'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StLatchOp,
        StLatchA,
        StLatchB,
        StLatchF,
        StReadY,
        StReadF,
        StResp
    } seq_state_t;

endpackage

// File: rtl/argon_pkg.sv
// Shared bus package for the ALU and its command sequencer.
// Provides the data word width, the ALU bus command encoding and the bit
// positions of the flags word (carry, zero, equal, greater, less, borrow).
package argon_pkg;

    localparam int unsigned WORDSIZE = 16;
    localparam int unsigned CMD_W    = 4;

    typedef logic [WORDSIZE-1:0] word_t;

    typedef enum logic [CMD_W-1:0] {
        com_idle    = 4'd0,
        com_latchA  = 4'd1,
        com_latchB  = 4'd2,
        com_latchF  = 4'd3,
        com_latchOp = 4'd4,
        com_outputY = 4'd5,
        com_outputF = 4'd6
    } command_t;

    // Bit positions inside the flags word
    localparam int unsigned F_CARRY   = 0;
    localparam int unsigned F_ZERO    = 1;
    localparam int unsigned F_EQUAL   = 2;
    localparam int unsigned F_GREATER = 3;
    localparam int unsigned F_LESS    = 4;
    localparam int unsigned F_BORROW  = 5;

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: turns one ALU operation request into the ALU bus command
// sequence (latch op/A/B/optional F, read Y, read F) and returns the captured
// result and flags words on a valid/ready response port.
//
// Ports:
//   i_Clk, i_Reset            clock, synchronous active-high reset
//   i_req_valid/o_req_ready   request handshake (ready only while idle)
//   i_req_op/a/b              opcode and operands
//   i_req_load_f/i_req_flags  optional flags preload before the reads
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_result/flags/error  ALU Y word, ALU F word, read-back timeout
//   o_bus_command/valid/data  command, write strobe and write data to the ALU
//   i_bus_data/i_bus_valid    combinational ALU read-back
module alu_sequencer #(
    parameter int unsigned WORDSIZE = argon_pkg::WORDSIZE,
    parameter int unsigned CMD_W    = argon_pkg::CMD_W,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [3:0]          i_req_op,
    input  logic [WORDSIZE-1:0] i_req_a,
    input  logic [WORDSIZE-1:0] i_req_b,
    input  logic                i_req_load_f,
    input  logic [WORDSIZE-1:0] i_req_flags,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [WORDSIZE-1:0] o_rsp_result,
    output logic [WORDSIZE-1:0] o_rsp_flags,
    output logic                o_rsp_error,
    output logic [CMD_W-1:0]    o_bus_command,
    output logic                o_bus_valid,
    output logic [WORDSIZE-1:0] o_bus_data,
    input  logic [WORDSIZE-1:0] i_bus_data,
    input  logic                i_bus_valid
);
    import argon_pkg::*;
    import alu_pkg::*;

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [3:0]          r_op;
    logic [WORDSIZE-1:0] r_a;
    logic [WORDSIZE-1:0] r_b;
    logic                r_load_f;
    logic [WORDSIZE-1:0] r_flags;
    logic                r_cache_valid;
    logic [3:0]          r_cache_op;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_next;
    logic                w_timeout;
    logic                w_accept;
    logic [WORDSIZE-1:0] r_result;
    logic [WORDSIZE-1:0] r_rsp_flags;
    logic                r_error;
    command_t            w_cmd;
    logic                w_bus_valid;
    logic [WORDSIZE-1:0] w_bus_data;

    assign w_accept = (r_state == StIdle) && i_req_valid;

    // Next-state logic; the wait counter only survives while a read state holds.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = '0;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    // Skip the opcode latch when the ALU already holds this opcode
                    w_state_next = (r_cache_valid && (r_cache_op == i_req_op)) ? StLatchA
                                                                               : StLatchOp;
                end
            end
            StLatchOp: w_state_next = StLatchA;
            StLatchA:  w_state_next = StLatchB;
            StLatchB:  w_state_next = r_load_f ? StLatchF : StReadY;
            StLatchF:  w_state_next = StReadY;
            StReadY, StReadF: begin
                if (i_bus_valid) begin
                    w_state_next = (r_state == StReadY) ? StReadF : StResp;
                end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                    w_state_next = StResp;
                    w_timeout    = 1'b1;
                end else begin
                    w_wait_next = r_wait + WAIT_W'(1);
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Bus drive decoded from the registered state
    always_comb begin
        w_cmd       = com_idle;
        w_bus_valid = 1'b0;
        w_bus_data  = '0;
        case (r_state)
            StLatchOp: begin
                w_cmd       = com_latchOp;
                w_bus_valid = 1'b1;
                w_bus_data  = WORDSIZE'(r_op);
            end
            StLatchA: begin
                w_cmd       = com_latchA;
                w_bus_valid = 1'b1;
                w_bus_data  = r_a;
            end
            StLatchB: begin
                w_cmd       = com_latchB;
                w_bus_valid = 1'b1;
                w_bus_data  = r_b;
            end
            StLatchF: begin
                w_cmd       = com_latchF;
                w_bus_valid = 1'b1;
                w_bus_data  = r_flags;
            end
            StReadY: w_cmd = com_outputY;
            StReadF: w_cmd = com_outputF;
            default: w_cmd = com_idle;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state       <= StIdle;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_load_f      <= 1'b0;
            r_flags       <= '0;
            r_cache_valid <= 1'b0;
            r_cache_op    <= '0;
            r_wait        <= '0;
            r_result      <= '0;
            r_rsp_flags   <= '0;
            r_error       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            if (w_accept) begin
                r_op     <= i_req_op;
                r_a      <= i_req_a;
                r_b      <= i_req_b;
                r_load_f <= i_req_load_f;
                r_flags  <= i_req_flags;
                r_error  <= 1'b0;
            end
            if (r_state == StLatchOp) begin
                r_cache_op    <= r_op;
                r_cache_valid <= 1'b1;
            end
            if ((r_state == StReadY) && i_bus_valid) begin
                r_result <= i_bus_data;
            end
            if ((r_state == StReadF) && i_bus_valid) begin
                r_rsp_flags <= i_bus_data;
            end
            // A missing read-back leaves the ALU state unknown, so drop the cache
            if (w_timeout) begin
                r_result      <= '0;
                r_rsp_flags   <= '0;
                r_error       <= 1'b1;
                r_cache_valid <= 1'b0;
            end
        end
    end

    assign o_req_ready   = (r_state == StIdle);
    assign o_rsp_valid   = (r_state == StResp);
    assign o_rsp_result  = r_result;
    assign o_rsp_flags   = r_rsp_flags;
    assign o_rsp_error   = r_error;
    assign o_bus_command = CMD_W'(w_cmd);
    assign o_bus_valid   = w_bus_valid;
    assign o_bus_data    = w_bus_data;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU on the bus side.
module tb_alu_sequencer;
    import argon_pkg::*;
    import alu_pkg::*;

    localparam int unsigned TO = 8;

    typedef struct {
        logic [15:0] result;
        logic [15:0] flags;
        logic        error;
        logic [31:0] trace;
        int          lat;
        int          acc;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] fl;
    } exp_t;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        req_valid  = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op     = '0;
    logic [15:0] req_a      = '0;
    logic [15:0] req_b      = '0;
    logic        req_load_f = 1'b0;
    logic [15:0] req_flags  = '0;
    logic        rsp_valid;
    logic        rsp_ready  = 1'b1;
    logic [15:0] rsp_result;
    logic [15:0] rsp_flags;
    logic        rsp_error;
    logic [3:0]  bus_command;
    logic        bus_valid;
    logic [15:0] bus_data;
    logic [15:0] bus_rdata;
    logic        bus_rvalid;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];

    int   rsp_mode   = 0;   // 0: always ready, 1: random, 2: held low
    logic rand_stall = 1'b0;
    logic bv_gate    = 1'b1;
    logic stall_y    = 1'b0;

    logic       ref_cache_valid = 1'b0;
    logic [3:0] ref_cache_op    = '0;
    logic [15:0] ref_alu_f      = '0;

    always #5 clk = ~clk;

    alu_sequencer #(.WORDSIZE(16), .CMD_W(4), .TIMEOUT(TO)) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_load_f (req_load_f),
        .i_req_flags  (req_flags),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_rsp_flags  (rsp_flags),
        .o_rsp_error  (rsp_error),
        .o_bus_command(bus_command),
        .o_bus_valid  (bus_valid),
        .o_bus_data   (bus_data),
        .i_bus_data   (bus_rdata),
        .i_bus_valid  (bus_rvalid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ALU behaviour: returns {F, Y}
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] fin);
        logic [16:0] wide;
        logic [15:0] y;
        logic [15:0] f;
        wide = '0;
        f    = '0;
        case (op)
            op_add:  wide = {1'b0, a} + {1'b0, b};
            op_adc:  wide = {1'b0, a} + {1'b0, b} + 17'(fin[F_CARRY]);
            op_sub:  wide = {1'b0, a} - {1'b0, b};
            op_and:  wide = {1'b0, a & b};
            op_or:   wide = {1'b0, a | b};
            op_xor:  wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
        y = wide[15:0];
        if (op == op_add || op == op_adc) f[F_CARRY] = wide[16];
        if (op == op_sub) f[F_BORROW] = (a < b);
        f[F_ZERO]    = (y == 16'h0);
        f[F_EQUAL]   = (a == b);
        f[F_GREATER] = (a > b);
        f[F_LESS]    = (a < b);
        return {f, y};
    endfunction

    // Bus-side ALU: latches on write strobes, answers reads combinationally
    logic [3:0]  alu_op_q = '0;
    logic [15:0] alu_a_q  = '0;
    logic [15:0] alu_b_q  = '0;
    logic [15:0] alu_f_q  = '0;
    logic [31:0] alu_out;

    initial forever begin
        @(negedge clk);
        if (bus_valid) begin
            case (bus_command)
                com_latchOp: alu_op_q = bus_data[3:0];
                com_latchA:  alu_a_q  = bus_data;
                com_latchB:  alu_b_q  = bus_data;
                com_latchF:  alu_f_q  = bus_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_out    = alu_ref(alu_op_q, alu_a_q, alu_b_q, alu_f_q);
        bus_rdata  = '0;
        bus_rvalid = 1'b0;
        if (bus_command == com_outputY) begin
            bus_rdata  = alu_out[15:0];
            bus_rvalid = bv_gate && !stall_y;
        end else if (bus_command == com_outputF) begin
            bus_rdata  = alu_out[31:16];
            bus_rvalid = bv_gate;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Read-back gaps stay well under the timeout (at most 3 consecutive low cycles)
    initial begin : gate_drv
        int low_run;
        low_run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_stall && low_run < 3) bv_gate = ($urandom_range(0, 3) != 0);
            else bv_gate = 1'b1;
            low_run = bv_gate ? 0 : low_run + 1;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: bus protocol, response stability and scoreboard pops
    initial begin : monitor
        exp_t        e;
        exp_t        cur;
        logic [15:0] h_res;
        logic [15:0] h_flg;
        logic        h_err;
        logic        held;
        logic        prev_valid;
        int          first_cyc;
        logic [31:0] trace;
        logic [3:0]  last_cmd;
        held = 1'b0; prev_valid = 1'b0; first_cyc = 0; trace = '0; last_cmd = 4'(com_idle);
        h_res = '0; h_flg = '0; h_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                trace = '0; last_cmd = 4'(com_idle); held = 1'b0; prev_valid = 1'b0;
            end else begin
                if (bus_command != 4'(com_idle) && bus_command != last_cmd)
                    trace = {trace[27:0], bus_command};
                last_cmd = bus_command;
                case (bus_command)
                    com_latchOp, com_latchA, com_latchB, com_latchF: begin
                        check("bus_valid_on_latch", 32'(bus_valid), 32'd1);
                        if (sb.size() != 0) begin
                            cur = sb[0];
                            case (bus_command)
                                com_latchOp: check("bus_data_op", 32'(bus_data), 32'(cur.op));
                                com_latchA:  check("bus_data_a", 32'(bus_data), 32'(cur.a));
                                com_latchB:  check("bus_data_b", 32'(bus_data), 32'(cur.b));
                                default:     check("bus_data_f", 32'(bus_data), 32'(cur.fl));
                            endcase
                        end
                    end
                    default: check("bus_valid_quiet", 32'(bus_valid), 32'd0);
                endcase
                if (rsp_valid) begin
                    check("req_ready_in_resp", 32'(req_ready), 32'd0);
                    check("bus_cmd_in_resp", 32'(bus_command), 32'(com_idle));
                    if (!prev_valid) first_cyc = cyc;
                    if (held) begin
                        check("stable_result", 32'(rsp_result), 32'(h_res));
                        check("stable_flags", 32'(rsp_flags), 32'(h_flg));
                        check("stable_error", 32'(rsp_error), 32'(h_err));
                    end
                    if (rsp_ready) begin
                        held = 1'b0;
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_rsp: got result 0x%0h, expected none", rsp_result);
                        end else begin
                            e = sb.pop_front();
                            check("rsp_result", 32'(rsp_result), 32'(e.result));
                            check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                            check("rsp_error", 32'(rsp_error), 32'(e.error));
                            check("cmd_trace", trace, e.trace);
                            if (e.lat != 0)
                                check("latency", 32'(first_cyc + 1 - e.acc), 32'(e.lat));
                        end
                        trace = '0;
                    end else begin
                        held = 1'b1; h_res = rsp_result; h_flg = rsp_flags; h_err = rsp_error;
                    end
                end else begin
                    held = 1'b0;
                end
                prev_valid = rsp_valid;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic lf, input logic [15:0] fl, input logic stall,
                         input logic lat_chk);
        exp_t        e;
        logic        hit;
        logic [31:0] pr;
        int          w;
        @(posedge clk);
        #1;
        stall_y    = stall;
        req_valid  = 1'b1;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        req_load_f = lf;
        req_flags  = fl;
        w = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            w++;
            if (w > 200) begin
                check("accept_timeout", 32'(req_ready), 32'd1);
                req_valid = 1'b0;
                return;
            end
        end
        hit = ref_cache_valid && (ref_cache_op == op);
        if (lf) ref_alu_f = fl;
        pr       = alu_ref(op, a, b, ref_alu_f);
        e.op     = op;
        e.a      = a;
        e.b      = b;
        e.fl     = fl;
        e.error  = stall;
        e.result = stall ? 16'h0 : pr[15:0];
        e.flags  = stall ? 16'h0 : pr[31:16];
        e.trace  = '0;
        if (!hit) e.trace = {e.trace[27:0], 4'(com_latchOp)};
        e.trace = {e.trace[27:0], 4'(com_latchA)};
        e.trace = {e.trace[27:0], 4'(com_latchB)};
        if (lf) e.trace = {e.trace[27:0], 4'(com_latchF)};
        e.trace = {e.trace[27:0], 4'(com_outputY)};
        if (!stall) e.trace = {e.trace[27:0], 4'(com_outputF)};
        e.lat = lat_chk ? ((hit ? 5 : 6) + (lf ? 1 : 0)) : 0;
        e.acc = cyc + 1;
        sb.push_back(e);
        ref_cache_valid = !stall;
        ref_cache_op    = op;
        @(posedge clk);
        #1;
        // Inputs are don't-care after the accept edge
        req_valid  = 1'b0;
        req_op     = 4'($urandom);
        req_a      = 16'($urandom);
        req_b      = 16'($urandom);
        req_load_f = 1'($urandom);
        req_flags  = 16'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            w++;
            if (w > 300) begin
                check("drain_timeout", 32'(sb.size()), 32'd0);
                sb.delete();
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : main
        int w;
        int r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        check("rst_bus_cmd", 32'(bus_command), 32'(com_idle));
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_data", 32'(bus_data), 32'd0);
        rst = 1'b0;

        issue(op_add, 16'h1234, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b1);
        drain();
        issue(op_add, 16'hFFFF, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b1);
        drain();

        // Back-to-back ADC: preload carry, then a cache hit
        issue(op_adc, 16'h0001, 16'h0001, 1'b1, 16'h0001 << F_CARRY, 1'b0, 1'b1);
        issue(op_adc, 16'h0001, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b1);
        drain();

        // Consumer stalls the response
        rsp_mode = 2;
        issue(op_or, 16'h00F0, 16'h0F00, 1'b0, 16'h0, 1'b0, 1'b1);
        w = 0;
        while (!rsp_valid && w <= 100) begin
            @(negedge clk);
            w++;
        end
        check("hold_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_bus_valid", 32'(bus_valid), 32'd0);
        end
        rsp_mode = 0;
        drain();

        // Read-back timeout, then the same op must re-latch the opcode
        issue(op_sub, 16'h0005, 16'h0003, 1'b0, 16'h0, 1'b1, 1'b0);
        drain();
        issue(op_sub, 16'h0005, 16'h0003, 1'b0, 16'h0, 1'b0, 1'b1);
        drain();

        // Reset in the middle of a sequence
        issue(op_xor, 16'hA5A5, 16'h0F0F, 1'b0, 16'h0, 1'b0, 1'b1);
        w = 0;
        while (bus_command != 4'(com_latchB) && w <= 20) begin
            @(negedge clk);
            w++;
        end
        check("reached_latch_b", 32'(bus_command), 32'(com_latchB));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_bus_valid", 32'(bus_valid), 32'd0);
        check("midrst_bus_cmd", 32'(bus_command), 32'(com_idle));
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        sb.delete();
        ref_cache_valid = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        issue(op_xor, 16'hA5A5, 16'h0F0F, 1'b0, 16'h0, 1'b0, 1'b1);
        drain();

        // Randomized traffic with read-back gaps and consumer backpressure
        rsp_mode   = 1;
        rand_stall = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 5));
            issue(4'(r < 3 ? r : r + 1), 16'($urandom), 16'($urandom), 1'($urandom),
                  16'($urandom), 1'b0, 1'b0);
        end
        drain();
        rsp_mode   = 0;
        rand_stall = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Upstream command sequencer for the ALU bus slave. It accepts one operation request (opcode, A, B, optional flags preload) over a valid/ready handshake. It issues the ALU bus command sequence one command per cycle, then captures the result word and flags word from the ALU read-back. The captured pair is returned on a valid/ready response port, which keeps the bus protocol out of the decode/execute logic.

Parameters:
WORDSIZE, 16, data word width; matches the ALU and the shared package.
CMD_W, 4, command field width; must equal the package command width.
TIMEOUT, 8, cycles to wait for the ALU read-back valid before aborting with an error.

Ports:
i_Clk  in  1  clock
i_Reset  in  1  reset; synchronous, active-high
i_req_valid  in  1  request present
o_req_ready  out  1  sequencer can accept a request (high only in IDLE)
i_req_op  in  4  ALU opcode
i_req_a  in  WORDSIZE  operand A
i_req_b  in  WORDSIZE  operand B
i_req_load_f  in  1  preload the ALU flags register before the reads
i_req_flags  in  WORDSIZE  flags preload value
o_rsp_valid  out  1  response present
i_rsp_ready  in  1  consumer takes the response
o_rsp_result  out  WORDSIZE  ALU Y word
o_rsp_flags  out  WORDSIZE  ALU F word
o_rsp_error  out  1  read-back timeout occurred
o_bus_command  out  CMD_W  command to the ALU
o_bus_valid  out  1  write strobe to the ALU (ALU i_valid)
o_bus_data  out  WORDSIZE  write data to the ALU (ALU i_data)
i_bus_data  in  WORDSIZE  ALU read data (ALU o_data)
i_bus_valid  in  1  ALU read valid (ALU o_valid)

Behaviour:
- Reset (sync, i_Reset high at a posedge):
  - state returns to IDLE.
  - Outputs: o_req_ready=1 (in IDLE), o_rsp_valid=0, o_rsp_error=0, o_rsp_result=0, o_rsp_flags=0, o_bus_command=com_idle, o_bus_valid=0, o_bus_data=0.
  - Op cache is invalidated; the wait counter is cleared.
  - Reset mid-sequence abandons the sequence; no response is produced.
- Request capture: in IDLE, i_req_valid & o_req_ready at a posedge captures op/a/b/load_f/flags into internal registers. The inputs are then don't-care.
- States, one cycle each unless stated:
  - IDLE.
  - LATCH_OP: command com_latchOp, bus_data={12'b0,op}, bus_valid=1.
  - LATCH_A: command com_latchA, data=a, bus_valid=1.
  - LATCH_B: command com_latchB, data=b, bus_valid=1.
  - LATCH_F: command com_latchF, data=flags, bus_valid=1.
  - READ_Y: command com_outputY, bus_valid=0.
  - READ_F: command com_outputF, bus_valid=0.
  - RESP.
- Transitions:
  - IDLE→LATCH_OP, or IDLE→LATCH_A if the op cache is valid and cached op == captured op.
  - LATCH_OP→LATCH_A→LATCH_B.
  - LATCH_B→LATCH_F if load_f, else LATCH_B→READ_Y.
  - LATCH_F→READ_Y.
  - READ_Y→READ_F→RESP.
- Op cache: updated to op and marked valid when LATCH_OP is issued.
- Read states:
  - The sequencer samples i_bus_data when i_bus_valid=1 in the same cycle; the ALU read path is combinational. It then advances.
  - While i_bus_valid=0 it holds the state and increments the wait counter.
  - When the counter reaches TIMEOUT, it goes to RESP with error=1 and result/flags=0, and invalidates the op cache.
  - The counter clears on every state change.
- RESP: o_rsp_valid=1 with stable data until i_rsp_ready=1 at a posedge, then returns to IDLE. No new request is accepted in the same cycle; o_req_ready is registered from the state.
- Latency, measured from the accept edge to o_rsp_valid high:
  - 6 cycles for a full sequence, no flags preload.
  - 7 cycles with load_f.
  - 5 cycles on an op-cache hit without load_f.
- Flags word layout follows the package bit positions: carry, zero, equal, greater, less, borrow. It is forwarded unmodified.

Decomposition:
- Shared package (argon_pkg): command enum (com_idle, com_latchA, com_latchB, com_latchF, com_latchOp, com_outputY, com_outputF), WORDSIZE, word_t, flag bit index constants (F_CARRY, etc.).
- alu_pkg: ALU opcode enum; the sequencer state enum is added here.
- Sub-modules: none required. The FSM and the capture registers sit in one module.

Test Plan:
- Reset, then ADD a=0x1234 b=0x0001 -> command trace latchOp,latchA,latchB,outputY,outputF; rsp_result=0x1235, carry=0, zero=0, greater=1; rsp_valid 6 cycles after accept.
- ADD a=0xFFFF b=0x0001 -> result=0x0000, carry=1, zero=1, greater=1.
- Two back-to-back ADC requests, first with load_f=1 and flags=1<<F_CARRY, a=0x0001 b=0x0001 -> first result=0x0003; second request has the same op, so no latchOp is issued and latency is 5 cycles.
- Hold i_rsp_ready=0 for 4 cycles -> rsp_valid and data stable, o_req_ready=0, no bus commands issued.
- Force i_bus_valid=0 in READ_Y -> after TIMEOUT=8 wait cycles, rsp_error=1, result=0; the next identical op reissues latchOp.
- Assert i_Reset during LATCH_B -> next cycle is IDLE, bus_valid=0, command=com_idle, no response; the following request issues latchOp.
